// File: rtl/izh_pkg.sv
// Shared fixed-point definitions for the Izhikevich neuron datapath:
// word format, saturation limits, integrator states and saturating add.
package izh_pkg;

    localparam int N = 32;
    localparam int Q = 16;

    localparam logic signed [N-1:0] FX_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] FX_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0] FX_ONE = {{(N-Q-1){1'b0}}, 1'b1, {Q{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DECAY,
        APPLY
    } integ_state_t;

    // Signed add that clamps to FX_MAX / FX_MIN instead of wrapping.
    function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
        logic signed [N:0] sum;
        sum = {a[N-1], a} + {b[N-1], b};
        if (sum[N] != sum[N-1])
            return sum[N] ? FX_MIN : FX_MAX;
        else
            return sum[N-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered occupancy count. A push into a
// full FIFO is refused even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since reads are gated by the count.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/synaptic_input_integrator.sv
// Buffers weighted spike events, accumulates them into a saturating Q16.16
// synaptic current, applies exponential decay once per timestep and hands
// the biased current to the neuron core with a one-cycle apply pulse.
module synaptic_input_integrator
    import izh_pkg::*;
#(
    parameter int N           = izh_pkg::N,
    parameter int Q           = izh_pkg::Q,
    parameter int DEPTH       = 8,
    parameter int DECAY_SHIFT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ev_valid,
    output logic         ev_ready,
    input  logic [N-1:0] ev_weight,
    input  logic         step,
    input  logic [N-1:0] bias,
    output logic [N-1:0] i_out,
    output logic         apply,
    output logic         busy,
    output logic         step_overrun
);

    localparam int AW = $clog2(DEPTH);

    integ_state_t       state;
    logic signed [N-1:0] acc;
    logic signed [N-1:0] decayed;
    logic [AW:0]        drain_cnt;
    logic [AW:0]        fifo_count;
    logic [N-1:0]       fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    assign ev_ready  = !fifo_full;
    assign fifo_push = ev_valid && ev_ready;
    assign decayed   = acc - (acc >>> DECAY_SHIFT);

    sync_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_event_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (ev_weight),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Pop freely while idle; during a drain pop only the entries snapshotted at the step.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            DRAIN:   fifo_pop = (drain_cnt != '0);
            default: fifo_pop = 1'b0;
        endcase
    end

    // Timestep FSM, accumulator and output register; the output is computed on
    // the DECAY->APPLY edge so apply and the new i_out appear together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            drain_cnt    <= '0;
            i_out        <= '0;
            apply        <= 1'b0;
            busy         <= 1'b0;
            step_overrun <= 1'b0;
        end else begin
            apply        <= 1'b0;
            step_overrun <= step && busy;
            if (fifo_pop)
                acc <= sat_add(acc, fifo_rdata);
            case (state)
                IDLE: begin
                    if (step) begin
                        drain_cnt <= fifo_count - {{AW{1'b0}}, fifo_pop};
                        state     <= DRAIN;
                        busy      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt != '0)
                        drain_cnt <= drain_cnt - 1'b1;
                    else
                        state <= DECAY;
                end
                DECAY: begin
                    acc   <= decayed;
                    i_out <= sat_add(decayed, bias);
                    apply <= 1'b1;
                    state <= APPLY;
                end
                APPLY: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synaptic_input_integrator.sv
// Directed self-checking bench for synaptic_input_integrator: reset,
// accumulate/decay, step snapshot boundary, saturation, backpressure,
// step overrun and reset in the middle of a timestep.
module tb_synaptic_input_integrator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic [31:0] ev_weight = '0;
    logic        step = 1'b0;
    logic [31:0] bias = '0;
    logic [31:0] i_out;
    logic        apply;
    logic        busy;
    logic        step_overrun;

    int compare_count = 0;
    int fail_count    = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    synaptic_input_integrator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_weight    (ev_weight),
        .step         (step),
        .bias         (bias),
        .i_out        (i_out),
        .apply        (apply),
        .busy         (busy),
        .step_overrun (step_overrun)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] weight, input logic stp);
        ev_valid  = valid;
        ev_weight = weight;
        step      = stp;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic push_event(input logic [31:0] w);
        applyStimulus(1'b1, w, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    // Caller has raised step for the current cycle; counts cycles up to apply.
    task automatic wait_apply(input string tag, input int exp_lat, input logic [31:0] exp_iout);
        int lat;
        next_cycle();
        step = 1'b0;
        lat  = 1;
        while (apply !== 1'b1 && lat < 40) begin
            next_cycle();
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, " i_out"}, i_out, exp_iout);
        next_cycle();
        checkOutput({tag, " apply drop"}, 32'(apply), 32'd0);
        checkOutput({tag, " busy drop"}, 32'(busy), 32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;

        // Reset held two cycles while an event is offered.
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h0001_0000, 1'b0);
        next_cycle();
        checkOutput("rst i_out", i_out, 32'h0);
        checkOutput("rst apply", 32'(apply), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst overrun", 32'(step_overrun), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        next_cycle();
        checkOutput("rst ev_ready", 32'(ev_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_apply("rst empty", 3, 32'h0);

        // Four events of 4.0 total, decayed by 1/8 -> 3.5.
        repeat (4) begin
            applyStimulus(1'b1, 32'h0001_0000, 1'b0);
            next_cycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (3) next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_apply("accum", 3, 32'h0003_8000);

        // Snapshot boundary: A,B,C queued while busy; the step cycle pops A and
        // drains B,C; D,E pushed during DRAIN wait for the next timestep.
        do_reset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        applyStimulus(1'b1, 32'h0001_0000, 1'b0);
        next_cycle();
        checkOutput("snap busy prior", 32'(busy), 32'd1);
        applyStimulus(1'b1, 32'h0002_0000, 1'b0);
        next_cycle();
        checkOutput("snap prior apply", 32'(apply), 32'd1);
        applyStimulus(1'b1, 32'h0004_0000, 1'b0);
        next_cycle();
        checkOutput("snap idle", 32'(busy), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        checkOutput("snap busy T+1", 32'(busy), 32'd1);
        checkOutput("snap ready T+1", 32'(ev_ready), 32'd1);
        applyStimulus(1'b1, 32'h0008_0000, 1'b0);
        next_cycle();
        applyStimulus(1'b1, 32'h0010_0000, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        next_cycle();
        checkOutput("snap apply T+4", 32'(apply), 32'd0);
        next_cycle();
        checkOutput("snap apply T+5", 32'(apply), 32'd1);
        checkOutput("snap i_out", i_out, 32'h0006_2000);
        repeat (4) next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_apply("snap next", 3, 32'h001A_5C00);

        // Positive saturation, then confirm bias never entered acc.
        do_reset();
        push_event(32'h7000_0000);
        push_event(32'h7000_0000);
        repeat (3) next_cycle();
        bias = 32'h1000_0000;
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_apply("sat pos", 3, 32'h7FFF_FFFF);
        bias = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_apply("sat pos acc", 3, 32'h6200_0000);

        // Negative saturation mirror.
        do_reset();
        push_event(32'h9000_0000);
        push_event(32'h9000_0000);
        repeat (3) next_cycle();
        bias = 32'hE000_0000;
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_apply("sat neg", 3, 32'h8000_0000);
        bias = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_apply("sat neg acc", 3, 32'h9E00_0000);

        // Backpressure: steps at cycles 0, 4 and 11 leave no-pop windows that
        // fill the FIFO; the ninth weighted event waits until cycle 22.
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            checkOutput($sformatf("bp ev_ready c%0d", c), 32'(ev_ready),
                        (c >= 19 && c <= 21) ? 32'd0 : 32'd1);
            checkOutput($sformatf("bp apply c%0d", c), 32'(apply),
                        (c == 3 || c == 10 || c == 20) ? 32'd1 : 32'd0);
            checkOutput($sformatf("bp busy c%0d", c), 32'(busy),
                        ((c >= 1 && c <= 3) || (c >= 5 && c <= 10) || (c >= 12 && c <= 20)) ? 32'd1 : 32'd0);
            if (c < 11)
                w = 32'h0;
            else if (c <= 18)
                w = 32'h0001_0000 << (c - 11);
            else
                w = 32'h0100_0000;
            applyStimulus(1'b1, w, (c == 0 || c == 4 || c == 11));
            next_cycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (10) next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        wait_apply("bp sum", 3, 32'h01BF_2000);

        // Step during DRAIN is ignored and flagged; exactly one apply follows.
        do_reset();
        push_event(32'h0008_0000);
        repeat (3) next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        checkOutput("ovr busy", 32'(busy), 32'd1);
        checkOutput("ovr flag T+1", 32'(step_overrun), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        checkOutput("ovr flag T+2", 32'(step_overrun), 32'd1);
        checkOutput("ovr apply T+2", 32'(apply), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        next_cycle();
        checkOutput("ovr apply T+3", 32'(apply), 32'd1);
        checkOutput("ovr i_out", i_out, 32'h0007_0000);
        checkOutput("ovr flag T+3", 32'(step_overrun), 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            checkOutput($sformatf("ovr no apply %0d", k), 32'(apply), 32'd0);
            checkOutput($sformatf("ovr idle %0d", k), 32'(busy), 32'd0);
        end

        // Reset asserted in DECAY aborts the step without an apply.
        push_event(32'h0001_0000);
        repeat (3) next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        next_cycle();
        checkOutput("rstdecay busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        next_cycle();
        checkOutput("rstdecay apply", 32'(apply), 32'd0);
        checkOutput("rstdecay i_out", i_out, 32'h0);
        checkOutput("rstdecay busy off", 32'(busy), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            checkOutput($sformatf("rstdecay no apply %0d", k), 32'(apply), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
